ddmtd_phase_tx: RTL
===================

// Module: ddmtd_phase_tx
// PURPOSE
// - Telemetry transmitter for the DDMTD phase detector: it consumes the (phase_valid, phase_err) strobe stream.
// - Buffers samples in a small FIFO and sends each one off-chip as a framed UART 8N1 packet on one pin.
// - The full 16-bit beat-domain error reaches the host, not just the 6 debug bits on uo_out.
// - Runs in the clk domain, beside the loop filter; reads the same phase_valid / phase_err_beat nets.
// PARAMETERS
// - ERR_W         16   phase_err width, 1..16; sign-extended to 16 bits for transmission
// - CLKS_PER_BIT  434  clk cycles per UART bit, >= 2 (434 = 50 MHz / 115200)
// - FIFO_DEPTH    4    sample FIFO entries, power of two, >= 2
// PORTS
// - clk          in   1               system clock
// - rst_n        in   1               reset: asynchronous, active-low
// - ena          in   1               tile enable
// - phase_valid  in   1               one-cycle strobe: a new measurement is on phase_err
// - phase_err    in   ERR_W           signed phase error, sampled when phase_valid=1
// - tx           out  1               UART serial out; idle high
// - busy         out  1               1 from the LOAD cycle through the end of the last stop bit
// - ovf          out  1               sticky: a sample was dropped because the FIFO was full
// - fifo_level   out  clog2(DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
// - Reset values: tx=1, busy=0, ovf=0, fifo_level=0, seq=0, FSM=IDLE.
//   Reset asserted mid-frame forces tx=1 immediately; the frame is abandoned and the FIFO is emptied.
// - Capture: on each edge where ena & phase_valid, seq increments (mod 256).
//   - If not full: {sext16(phase_err), seq_before_increment} is written to the FIFO.
//   - If full: the sample is dropped, ovf<=1, and seq still increments, so the host sees the gap.
// - Full FIFO + pop + write on the same edge: the write is accepted and level is unchanged.
// - ena=0: no captures, and no new frame starts; a frame already in BIT state completes normally.
// - Frame bytes, in order:
//   - 0xA5 (SYNC)
//   - err[15:8]
//   - err[7:0]
//   - seq
//   - optional checksum byte (see CONFIGURATION)
// - Each byte is sent as 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
// - Every bit lasts exactly CLKS_PER_BIT cycles. Bytes within a frame are back-to-back, with no idle gap.
// - FSM states:
//   - IDLE -> LOAD when the FIFO is non-empty and ena=1.
//   - LOAD (1 cycle): pop the FIFO, latch the frame shift register, set busy=1, tx stays 1.
//   - LOAD -> BIT.
//   - BIT: serialise FRAME_LEN*10 bits; after the last stop bit -> IDLE with busy=0.
// - Latency: phase_valid at edge E0 into an empty, idle block gives LOAD at E1 and tx falling at E2.
// - Between consecutive frames tx is high for exactly 2 cycles (IDLE + LOAD).
// - The bit counter and baud counter wrap to 0 at a frame boundary. seq wraps 255 -> 0.
// CONFIGURATION
// - Macro PHASE_TX_CSUM_EN defined:
//   - FRAME_LEN=5; byte 5 = (-(err_hi + err_lo + seq)) mod 256.
//   - So the 8-bit sum of bytes 2..5 is 0x00.
// - Macro PHASE_TX_CSUM_EN undefined: FRAME_LEN=4, and there is no checksum byte or checksum logic.
// STRUCTURE
// - Package ddmtd_pkg holds:
//   - SYNC_BYTE = 8'hA5
//   - FRAME_LEN_BASE = 4
//   - the FSM state enum {IDLE, LOAD, BIT}
//   - the function sext16()
// - Sub-module uart_tx_byte: start/data/stop serializer with its baud counter and a ready/done handshake.
// - Top level keeps the FIFO, seq counter, frame sequencer and the optional checksum.
// TESTING (use CLKS_PER_BIT=4, FIFO_DEPTH=4)
// - Reset, then phase_err=16'h1234 strobed once:
//   - tx falls 2 edges later.
//   - Bytes decode as A5 12 34 00 (+BA with CSUM_EN).
//   - busy lasts 1 + 160 cycles (1 + 200 with CSUM_EN).
// - ERR_W=12, phase_err=12'hFFF -> err bytes FF FF.
// - Two strobes 3 cycles apart:
//   - Second frame seq=01.
//   - tx high for exactly 2 cycles between the frames.
// - Six strobes while the first frame is in flight:
//   - ovf=1 and fifo_level saturates at 4.
//   - Transmitted seq: 00 01 02 03 04, then 06 after the drop.
// - Full FIFO, strobe on the LOAD cycle -> the sample is accepted, fifo_level stays 4, ovf stays 0.
// - rst_n low mid-byte -> tx=1 asynchronously; after release, the next strobe sends seq 00.

Source files
------------

// File: rtl/ddmtd_pkg.sv
// Shared types and constants for the DDMTD phase telemetry transmitter.
// PHASE_TX_CSUM_EN appends a checksum byte to every frame (FRAME_LEN 5 instead of 4).
package ddmtd_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         FRAME_LEN_BASE = 4;

`ifdef PHASE_TX_CSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BIT  = 2'd2
  } state_e;

  // Sign-extend the low w bits of v (1 <= w <= 16) to a full 16-bit value.
  function automatic logic [15:0] sext16(input logic [15:0] v, input int w);
    logic [15:0] keep;
    logic        sign;
    keep = 16'hFFFF >> (16 - w);
    sign = |(v & (16'h0001 << (w - 1)));
    return sign ? (v | ~keep) : (v & keep);
  endfunction

endpackage

// File: rtl/ddmtd_phase_tx_if.sv
// Phase-measurement strobe stream from the DDMTD detector into the transmitter.
// phase_err is meaningful only in a cycle where phase_valid=1; there is no back-pressure.
interface ddmtd_phase_tx_if #(
  parameter int ERR_W = 16
);
  logic             phase_valid;
  logic [ERR_W-1:0] phase_err;

  modport master (output phase_valid, output phase_err);
  modport slave  (input  phase_valid, input  phase_err);
endinterface

// File: rtl/ddmtd_phase_tx_uart_tx_byte.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB-first, stop bit, each CLKS_PER_BIT cycles.
// Handshake: a byte is accepted on an edge where start=1 and ready=1. ready is high while idle and
// also during the last cycle of the stop bit, so a new byte can follow with no idle gap; done pulses
// for exactly that last stop-bit cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    shreg;
  logic          bit_end;
  logic          last;

  assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last    = active && bit_end && (bit_idx == 4'd9);
  assign ready   = !active || last;
  assign done    = last;
  // Combinational from reset-cleared state so an asynchronous reset releases the line at once.
  assign tx      = active ? shreg[0] : 1'b1;

  // Baud counter, bit index and shift register; a new byte restarts all of them from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
    end else if (start && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= {1'b1, data, 1'b0};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddmtd_phase_tx.sv
// DDMTD phase telemetry transmitter: captures (seq, sign-extended phase error) samples into a FIFO
// and sends each as a framed UART packet: A5, err_hi, err_lo, seq [, checksum].
// PHASE_TX_CSUM_EN adds the checksum byte making the 8-bit sum of err_hi+err_lo+seq+csum zero.
module ddmtd_phase_tx
  import ddmtd_pkg::*;
#(
  parameter int ERR_W        = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  ddmtd_phase_tx_if.slave             phase,
  output logic                        tx,
  output logic                        busy,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output state_e                      fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (FRAME_LEN - 1) * 8;

  // FIFO entry layout: {err16, seq}
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, capture, push, pop;
  logic [7:0]    seq;
  logic [15:0]   err_raw;
  logic [23:0]   head;

  state_e        state_q, state_d;
  logic [FW-1:0] frame, frame_load;
  logic [2:0]    byte_idx;
  logic          start;
  logic [7:0]    tx_data;
  logic          ser_ready, ser_done;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign capture = ena && phase.phase_valid;
  assign pop     = (state_q == LOAD);
  // A full FIFO still accepts a sample when the same edge pops the head.
  assign push    = capture && (!full || pop);
  assign err_raw = 16'(phase.phase_err);
  assign head    = mem[rd_ptr];

`ifdef PHASE_TX_CSUM_EN
  logic [7:0] csum;
  assign csum       = 8'h00 - head[23:16] - head[15:8] - head[7:0];
  assign frame_load = {head, csum};
`else
  assign frame_load = head;
`endif

  assign busy       = (state_q != IDLE);
  assign fifo_level = level;
  assign fsm_state  = state_q;

  // FIFO storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sext16(err_raw, ERR_W), seq};
  end

  // FIFO pointers, occupancy, sequence counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      seq    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (capture) seq <= seq + 8'd1;
      if (capture && !push) ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Frame sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and byte launch: SYNC goes out from LOAD, the rest follow on each byte's done.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    tx_data = SYNC_BYTE;
    case (state_q)
      IDLE: if (ena && !empty) state_d = LOAD;
      LOAD: begin
        start   = 1'b1;
        tx_data = SYNC_BYTE;
        state_d = BIT;
      end
      BIT: begin
        if (ser_done) begin
          if (byte_idx == 3'(FRAME_LEN)) begin
            state_d = IDLE;
          end else begin
            start   = ser_ready;
            tx_data = frame[FW-1 -: 8];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame payload shift register and count of bytes already handed to the serializer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame    <= '0;
      byte_idx <= '0;
    end else if (state_q == LOAD) begin
      frame    <= frame_load;
      byte_idx <= 3'd1;
    end else if (start) begin
      frame    <= {frame[FW-9:0], 8'h00};
      byte_idx <= byte_idx + 3'd1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (tx_data),
    .tx    (tx),
    .ready (ser_ready),
    .done  (ser_done)
  );

endmodule
